// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI mode-0 slave that returns a sample word and captures a command word.
// Define SPI_RESP_FRAME_ERR_EN to enable frame_err_o (aborted frame / HOLD overrun reporting).
module spi_adc_responder #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK_48,
    input  logic                  RESET_N,
    input  logic                  sclk_pad_i,
    input  logic                  ss_pad_i,
    input  logic                  mosi_pad_i,
    output logic                  miso_pad_o,
    output logic                  miso_oe_o,
    input  logic [FRAME_BITS-1:0] tx_data_i,
    output logic [FRAME_BITS-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  frame_err_o
);
    localparam int            CW       = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;
    logic [SYNC_STAGES:0]   r_flush;
    logic                   r_armed;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [FRAME_BITS-1:0]  r_tx_shift;
    logic [FRAME_BITS-1:0]  r_rx_shift;
    logic [CW-1:0]          r_bit_cnt;
    logic                   r_miso;
    logic                   r_oe;
    logic                   r_busy;
    logic [FRAME_BITS-1:0]  r_rx_data;
    logic                   r_rx_valid;

    logic [FRAME_BITS-1:0]  w_tx_nxt;
    logic [FRAME_BITS-1:0]  w_rx_nxt;
    logic [FRAME_BITS-1:0]  w_rx_shifted;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_miso_nxt;
    logic                   w_oe_nxt;
    logic                   w_busy_nxt;
    logic [FRAME_BITS-1:0]  w_rx_data_nxt;
    logic                   w_rx_valid_nxt;

    logic w_sclk_s;
    logic w_ss_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_rise;
    logic w_ss_fall;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ss_rise   = w_ss_s & ~r_ss_d;
    assign w_ss_fall   = ~w_ss_s & r_ss_d;

    assign w_rx_shifted = (r_rx_shift << 1) | {{(FRAME_BITS-1){1'b0}}, w_mosi_s};

    // Pad synchronizers plus one delay flop per control line for edge detection.
    always_ff @(posedge CLK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sclk_sync <= {SYNC_STAGES{1'b0}};
            r_ss_sync   <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_pad_i};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_pad_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_pad_i};
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= w_ss_s;
        end
    end

    // Arm only after real ss-high is seen, so a reset released mid-frame waits for a fresh select.
    always_ff @(posedge CLK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_flush <= {(SYNC_STAGES+1){1'b0}};
            r_armed <= 1'b0;
        end else begin
            r_flush <= {r_flush[SYNC_STAGES-1:0], 1'b1};
            if (r_flush[SYNC_STAGES] && w_ss_s) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end

    // Next-state and datapath decode; ss events take priority over SCLK edges.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_nxt       = r_tx_shift;
        w_rx_nxt       = r_rx_shift;
        w_cnt_nxt      = r_bit_cnt;
        w_miso_nxt     = r_miso;
        w_oe_nxt       = r_oe;
        w_busy_nxt     = r_busy;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_miso_nxt = 1'b0;
                w_oe_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
                if (w_ss_fall && r_armed) begin
                    w_state_nxt = ST_SHIFT;
                    w_tx_nxt    = tx_data_i;
                    w_rx_nxt    = {FRAME_BITS{1'b0}};
                    w_cnt_nxt   = CNT_ZERO;
                    w_miso_nxt  = tx_data_i[FRAME_BITS-1];
                    w_oe_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_miso_nxt  = 1'b0;
                    w_oe_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (w_sclk_rise) begin
                    w_rx_nxt  = w_rx_shifted;
                    w_cnt_nxt = r_bit_cnt + CNT_ONE;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt    = ST_HOLD;
                        w_rx_data_nxt  = w_rx_shifted;
                        w_rx_valid_nxt = 1'b1;
                        w_miso_nxt     = 1'b0;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else if (w_sclk_fall && (r_bit_cnt != CNT_ZERO)) begin
                    w_tx_nxt   = r_tx_shift << 1;
                    w_miso_nxt = r_tx_shift[FRAME_BITS-2];
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                w_miso_nxt = 1'b0;
                if (w_ss_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_oe_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_miso_nxt  = 1'b0;
                w_oe_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift registers, counter and registered outputs.
    always_ff @(posedge CLK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tx_shift <= {FRAME_BITS{1'b0}};
            r_rx_shift <= {FRAME_BITS{1'b0}};
            r_bit_cnt  <= CNT_ZERO;
            r_miso     <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_data  <= {FRAME_BITS{1'b0}};
            r_rx_valid <= 1'b0;
        end else begin
            r_tx_shift <= w_tx_nxt;
            r_rx_shift <= w_rx_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            r_miso     <= w_miso_nxt;
            r_oe       <= w_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    assign miso_pad_o = r_miso;
    assign miso_oe_o  = r_oe;
    assign busy_o     = r_busy;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;

`ifdef SPI_RESP_FRAME_ERR_EN
    logic r_frame_err;
    logic r_err_done;
    logic w_err_abort;
    logic w_err_overrun;

    assign w_err_abort   = (r_state == ST_SHIFT) && w_ss_rise;
    assign w_err_overrun = (r_state == ST_HOLD) && !w_ss_rise && w_sclk_rise && !r_err_done;

    // Error strobe; overrun is reported once per frame.
    always_ff @(posedge CLK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_frame_err <= 1'b0;
            r_err_done  <= 1'b0;
        end else begin
            r_frame_err <= w_err_abort | w_err_overrun;
            if (r_state == ST_IDLE) begin
                r_err_done <= 1'b0;
            end else if (w_err_overrun) begin
                r_err_done <= 1'b1;
            end else begin
                r_err_done <= r_err_done;
            end
        end
    end

    assign frame_err_o = r_frame_err;
`else
    assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_adc_responder.sv
// Self-checking bench for spi_adc_responder: SPI master model with an rx scoreboard queue.
module tb_spi_adc_responder;
    localparam int FB   = 16;
    localparam int CLKP = 20;
    localparam int HP   = 80;
`ifdef SPI_RESP_FRAME_ERR_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          sclk  = 1'b0;
    logic          ss    = 1'b1;
    logic          mosi  = 1'b0;
    logic [FB-1:0] tx_data = 16'h0000;
    logic          miso;
    logic          oe;
    logic [FB-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          frame_err;

    int n_total = 0;
    int n_bad   = 0;
    int n_valid = 0;
    int n_err   = 0;
    logic [FB-1:0] exp_q[$];

    spi_adc_responder #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .CLK_48      (clk),
        .RESET_N     (rst_n),
        .sclk_pad_i  (sclk),
        .ss_pad_i    (ss),
        .mosi_pad_i  (mosi),
        .miso_pad_o  (miso),
        .miso_oe_o   (oe),
        .tx_data_i   (tx_data),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .busy_o      (busy),
        .frame_err_o (frame_err)
    );

    always #(CLKP/2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        #HP;
        m    = miso;
        sclk = 1'b1;
        #HP;
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [31:0] w, input int n, output logic [31:0] rd);
        logic m;
        rd = 32'd0;
        ss = 1'b0;
        #(8*CLKP);
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(w[i], m);
            rd = {rd[30:0], m};
        end
        #HP;
        ss = 1'b1;
    endtask

    // Scoreboard: every rx_valid strobe must match the oldest pending command word.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
            else check("rx_data", {16'h0000, rx_data}, {16'h0000, exp_q.pop_front()});
        end
        if (frame_err) n_err++;
    end

    initial begin
        #(200000*CLKP);
        $display("FAIL watchdog: sim time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] rd2;
        logic [31:0] w18;
        int          v0;
        int          e0;
        logic        act;
        logic        m;

        #1 rst_n = 1'b0;
        #2;
        check("rst_miso", miso, 32'd0);
        check("rst_oe", oe, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_valid", rx_valid, 32'd0);
        check("rst_rxdata", rx_data, 32'd0);
        check("rst_err", frame_err, 32'd0);
        #(5*CLKP) rst_n = 1'b1;
        #(10*CLKP);

        // basic frame
        tx_data = 16'hA5C3; v0 = n_valid; e0 = n_err;
        exp_q.push_back(16'h8100);
        fork
            spi_frame(32'h8100, 16, rd);
            begin
                #(10*CLKP);
                check("f1_busy", busy, 32'd1);
                check("f1_oe", oe, 32'd1);
            end
        join
        #(10*CLKP);
        check("f1_read", rd[15:0], 32'hA5C3);
        check("f1_nvalid", n_valid - v0, 32'd1);
        check("f1_rxdata", rx_data, 32'h8100);
        check("f1_err", n_err - e0, 32'd0);
        check("idle_busy", busy, 32'd0);
        check("idle_oe", oe, 32'd0);
        check("idle_miso", miso, 32'd0);

        // tx_data changes mid-frame
        tx_data = 16'h1234;
        exp_q.push_back(16'h4C2B);
        fork
            spi_frame(32'h4C2B, 16, rd);
            begin
                #(8*CLKP + 12*HP);
                tx_data = 16'hFFFF;
            end
        join
        #(10*CLKP);
        check("f2_read", rd[15:0], 32'h1234);

        // aborted after 9 bits
        tx_data = 16'h5555; v0 = n_valid; e0 = n_err;
        spi_frame(32'h01FF, 9, rd);
        #(10*CLKP);
        check("abort_read", rd[8:0], 32'h0AA);
        check("abort_nvalid", n_valid - v0, 32'd0);
        check("abort_rxdata", rx_data, 32'h4C2B);
        check("abort_err", n_err - e0, EXP_ERR);

        // 18 clocks: overrun into HOLD
        tx_data = 16'h0F0F; v0 = n_valid; e0 = n_err;
        w18 = 32'h0002ABCD;
        exp_q.push_back(w18[17:2]);
        spi_frame(w18, 18, rd);
        #(10*CLKP);
        check("ovr_read", rd[17:2], 32'h0F0F);
        check("ovr_tail", rd[1:0], 32'd0);
        check("ovr_nvalid", n_valid - v0, 32'd1);
        check("ovr_rxdata", rx_data, {16'h0000, w18[17:2]});
        check("ovr_err", n_err - e0, EXP_ERR);

        // reset at bit 7, released with ss still low
        tx_data = 16'hC3C3; v0 = n_valid;
        ss = 1'b0;
        #(8*CLKP);
        for (int i = 0; i < 7; i++) spi_bit(1'b1, m);
        rst_n = 1'b0;
        #1;
        check("mrst_out", {miso, oe, busy, rx_valid, frame_err}, 32'd0);
        check("mrst_rxdata", rx_data, 32'd0);
        #(2*CLKP - 1);
        rst_n = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 9; i++) begin
            spi_bit(1'b0, m);
            act = act | m | busy | oe | rx_valid;
        end
        #HP;
        check("mrst_quiet", act, 32'd0);
        check("mrst_nvalid", n_valid - v0, 32'd0);
        ss = 1'b1;
        #(10*CLKP);
        tx_data = 16'h3C3C;
        exp_q.push_back(16'h7E81);
        spi_frame(32'h7E81, 16, rd);
        #(10*CLKP);
        check("mrst_read", rd[15:0], 32'h3C3C);
        check("mrst_nvalid2", n_valid - v0, 32'd1);

        // back-to-back frames, ss high 4 cycles
        v0 = n_valid;
        tx_data = 16'h1111;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'hFFFE);
        spi_frame(32'h0001, 16, rd);
        #(4*CLKP);
        tx_data = 16'h2222;
        spi_frame(32'hFFFE, 16, rd2);
        #(10*CLKP);
        check("b2b_read1", rd[15:0], 32'h1111);
        check("b2b_read2", rd2[15:0], 32'h2222);
        check("b2b_nvalid", n_valid - v0, 32'd2);
        check("b2b_rxdata", rx_data, 32'hFFFE);

        check("q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
